// File: rtl/stdout_ctrl_pkg.sv
// Shared types and constants for the stdout console controller.
//   mem_store_type_t : store kind presented by the core's store port
//   stdout_state_t   : controller FSM states
//   stdout_status_t  : layout of the readable status word
// Optional feature macro used by this slice: STDOUT_LINE_BUFFER_EN
package stdout_ctrl_pkg;

  typedef enum logic [1:0] {
    NO_STORE    = 2'd0,
    STORE_BYTE  = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_DWORD = 2'd3
  } mem_store_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } stdout_state_t;

  localparam int unsigned   BYTE_W              = 8;
  localparam int unsigned   STDOUT_WINDOW_BYTES = 8;
  localparam int unsigned   STDOUT_FIFO_DEPTH   = 16;
  localparam logic [63:0]   STDOUT_BASE_ADDR    = 64'h0000_0000_1000_0000;
  localparam logic [63:0]   STDOUT_STATUS_ADDR  = STDOUT_BASE_ADDR + 64'd8;
  localparam logic [7:0]    ASCII_NEWLINE       = 8'h0A;

  typedef struct packed {
    logic [47:0] rsvd_hi;
    logic [7:0]  count;
    logic [4:0]  rsvd_lo;
    logic        busy;
    logic        empty;
    logic        full;
  } stdout_status_t;

  // Number of bytes a multi-byte store is split into.
  function automatic logic [3:0] split_len(input mem_store_type_t t);
    return (t == STORE_WORD) ? 4'd4 : 4'd8;
  endfunction

endpackage

// File: rtl/stdout_fifo.sv
// Byte FIFO feeding the host console stream.
// Ports:
//   i_clock, i_reset      : clock, synchronous active-high reset
//   i_push, i_push_data   : enqueue request (ignored when full) and byte
//   i_pop                 : dequeue head (ignored when empty)
//   o_head                : byte at the head of the queue
//   o_count, o_full, o_empty : occupancy
//   o_valid               : head may be offered to the host
// Macro STDOUT_LINE_BUFFER_EN: hold bytes back until a newline is queued
// (or the FIFO is full).
module stdout_fifo
  import stdout_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [BYTE_W-1:0]         i_push_data,
  input  logic                      i_pop,
  output logic [BYTE_W-1:0]         o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Push is gated by the registered full flag; a same-cycle pop does not help.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage array, no reset needed.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef STDOUT_LINE_BUFFER_EN
  logic [CNT_W-1:0] r_nl_count;
  logic             w_nl_in;
  logic             w_nl_out;

  assign w_nl_in  = w_push && (i_push_data == ASCII_NEWLINE);
  assign w_nl_out = w_pop && (o_head == ASCII_NEWLINE);

  // Number of newlines currently held in the queue.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_nl_count <= '0;
    end else begin
      case ({w_nl_in, w_nl_out})
        2'b10:   r_nl_count <= r_nl_count + CNT_W'(1);
        2'b01:   r_nl_count <= r_nl_count - CNT_W'(1);
        default: r_nl_count <= r_nl_count;
      endcase
    end
  end

  assign o_valid = !o_empty && ((r_nl_count != '0) || o_full);
`else
  assign o_valid = !o_empty;
`endif

endmodule

// File: rtl/stdout_ctrl.sv
// Simulation-console controller: decodes stores to the stdout MMIO window,
// splits WORD/DWORD stores into little-endian bytes (one per cycle), queues
// them in stdout_fifo and drains them over a valid/ready byte stream.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   addr, mem_store_type, w_data : core store port
//   stall                  : combinational backpressure to the core
//   r_data                 : status word when addr == STDOUT_STATUS_ADDR, else 0
//   stdout_taken           : one-cycle pulse after a store is accepted
//   out_valid, out_byte, out_ready : byte stream to the host
// Macro STDOUT_LINE_BUFFER_EN (in stdout_fifo): line-buffered draining.
module stdout_ctrl
  import stdout_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = STDOUT_FIFO_DEPTH,
  parameter int unsigned SKIP_NUL = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     addr,
  input  mem_store_type_t mem_store_type,
  input  logic [63:0]     w_data,
  output logic            stall,
  output logic [63:0]     r_data,
  output logic            stdout_taken,
  output logic            out_valid,
  output logic [7:0]      out_byte,
  input  logic            out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  stdout_state_t  r_state;
  logic [63:0]    r_shift;
  logic [3:0]     r_remaining;
  logic           r_taken;

  logic           w_hit;
  logic           w_is_byte;
  logic           w_full;
  logic           w_empty;
  logic [CNT_W-1:0] w_count;
  logic           w_push;
  logic [7:0]     w_push_data;
  logic           w_accept;
  logic           w_split_step;
  logic           w_pop;
  stdout_status_t w_status;

  // Address decode: any store landing in the 8-byte stdout window.
  assign w_hit = (mem_store_type != NO_STORE)
              && (addr >= STDOUT_BASE_ADDR)
              && (addr <  STDOUT_BASE_ADDR + 64'(STDOUT_WINDOW_BYTES));
  assign w_is_byte = (mem_store_type == STORE_BYTE);

  // Multi-byte stores are always taken in IDLE; they wait in SPLIT for space.
  assign stall = w_hit && !((r_state == ST_IDLE) && (!w_is_byte || !w_full));

  // Accept / enqueue decisions for this cycle.
  always_comb begin
    w_push       = 1'b0;
    w_push_data  = w_data[7:0];
    w_accept     = 1'b0;
    w_split_step = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_hit) begin
        if (w_is_byte) begin
          if (!w_full) begin
            w_push   = 1'b1;
            w_accept = 1'b1;
          end
        end else begin
          w_accept = 1'b1;
        end
      end
    end else begin
      if (!w_full) begin
        w_split_step = 1'b1;
        w_push_data  = r_shift[7:0];
        w_push       = !((SKIP_NUL != 0) && (r_shift[7:0] == 8'h00));
      end
    end
  end

  // Controller FSM: IDLE takes stores, SPLIT emits one byte per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_remaining <= '0;
      r_taken     <= 1'b0;
    end else begin
      r_taken <= w_accept;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_is_byte) begin
            r_shift     <= (mem_store_type == STORE_WORD) ? {32'h0, w_data[31:0]} : w_data;
            r_remaining <= split_len(mem_store_type);
            r_state     <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (w_split_step) begin
            r_shift     <= {8'h00, r_shift[63:8]};
            r_remaining <= r_remaining - 4'd1;
            if (r_remaining == 4'd1) r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign stdout_taken = r_taken;
  assign w_pop        = out_valid && out_ready;

  stdout_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (out_byte),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_valid     (out_valid)
  );

  // Status word, only driven when the status address is presented.
  always_comb begin
    w_status       = '0;
    w_status.full  = w_full;
    w_status.empty = w_empty;
    w_status.busy  = (r_state == ST_SPLIT);
    w_status.count = 8'(w_count);
    r_data         = (addr == STDOUT_STATUS_ADDR) ? w_status : 64'h0;
  end

endmodule

// File: tb/tb_stdout_ctrl.sv
module tb_stdout_ctrl;
  import stdout_ctrl_pkg::*;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned SKIP_NUL = 1;
  localparam int          BUDGET   = 200;
  localparam logic [63:0] BASE     = STDOUT_BASE_ADDR;
  localparam logic [63:0] STATUS   = STDOUT_STATUS_ADDR;

  logic            clock;
  logic            reset;
  logic [63:0]     addr;
  mem_store_type_t mem_store_type;
  logic [63:0]     w_data;
  logic            stall;
  logic [63:0]     r_data;
  logic            stdout_taken;
  logic            out_valid;
  logic [7:0]      out_byte;
  logic            out_ready;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;

  // Reference model state: bytes in the FIFO, bytes still to be split,
  // and the scoreboard of bytes the host must receive in order.
  logic [7:0] m_fifo[$];
  logic [7:0] m_pend[$];
  logic [7:0] sb_q[$];
  logic       m_taken = 1'b0;
  logic       m_live  = 1'b0;

  stdout_ctrl #(.DEPTH(DEPTH), .SKIP_NUL(SKIP_NUL)) dut (
    .clock          (clock),
    .reset          (reset),
    .addr           (addr),
    .mem_store_type (mem_store_type),
    .w_data         (w_data),
    .stall          (stall),
    .r_data         (r_data),
    .stdout_taken   (stdout_taken),
    .out_valid      (out_valid),
    .out_byte       (out_byte),
    .out_ready      (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level reference model evaluated on the falling edge.
  always @(negedge clock) begin : model
    logic full_m, empty_m, busy_m, hit_m, stall_m, valid_m, pop_m, taken_n;
    logic [63:0] rdata_m;
    logic [7:0]  b;
    int          n;
    if (reset) begin
      m_fifo.delete();
      m_pend.delete();
      sb_q.delete();
      m_taken = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      full_m  = (m_fifo.size() == DEPTH);
      empty_m = (m_fifo.size() == 0);
      busy_m  = (m_pend.size() != 0);
      hit_m   = (addr >= BASE) && (addr < BASE + 64'd8) && (mem_store_type != NO_STORE);
      stall_m = hit_m && (busy_m || ((mem_store_type == STORE_BYTE) && full_m));
`ifdef STDOUT_LINE_BUFFER_EN
      n = 0;
      foreach (m_fifo[k]) if (m_fifo[k] == 8'h0A) n++;
      valid_m = !empty_m && ((n != 0) || full_m);
`else
      valid_m = !empty_m;
`endif
      rdata_m = (addr == STATUS) ?
                {48'h0, 8'(m_fifo.size()), 5'h0, busy_m, empty_m, full_m} : 64'h0;
      check("stall", 64'(stall), 64'(stall_m));
      check("out_valid", 64'(out_valid), 64'(valid_m));
      check("stdout_taken", 64'(stdout_taken), 64'(m_taken));
      check("r_data", r_data, rdata_m);

      pop_m   = valid_m && out_ready;
      taken_n = 1'b0;
      if (pop_m) void'(m_fifo.pop_front());
      if (busy_m) begin
        if (!full_m) begin
          b = m_pend.pop_front();
          if (!((SKIP_NUL != 0) && (b == 8'h00))) m_fifo.push_back(b);
        end
      end else if (hit_m) begin
        if (mem_store_type == STORE_BYTE) begin
          if (!full_m) begin
            m_fifo.push_back(w_data[7:0]);
            sb_q.push_back(w_data[7:0]);
            taken_n = 1'b1;
          end
        end else begin
          n = (mem_store_type == STORE_WORD) ? 4 : 8;
          for (int i = 0; i < n; i++) begin
            b = w_data[8*i +: 8];
            m_pend.push_back(b);
            if (!((SKIP_NUL != 0) && (b == 8'h00))) sb_q.push_back(b);
          end
          taken_n = 1'b1;
        end
      end
      m_taken = taken_n;
    end
  end

  // Monitor: every byte the host takes must be the next scoreboard entry.
  always @(negedge clock) begin : monitor
    logic [7:0] e;
    if (!reset && m_live && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_byte: got %h expected none at %0t", out_byte, $time);
      end else begin
        e = sb_q.pop_front();
        check("out_byte", 64'(out_byte), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle(input logic [63:0] a, input int n);
    addr           = a;
    mem_store_type = NO_STORE;
    repeat (n) tick();
  endtask

  // Present a store and hold it until stall drops; returns stalled cycles.
  task automatic do_store(input logic [63:0] a, input mem_store_type_t t,
                          input logic [63:0] d, output int stalls);
    addr           = a;
    mem_store_type = t;
    w_data         = d;
    stalls         = 0;
    forever begin
      @(negedge clock);
      if (!stall) break;
      stalls++;
      if (stalls > BUDGET) begin
        n_vec++;
        n_err++;
        $display("FAIL store_timeout: got stall after %0d cycles expected accept", stalls);
        break;
      end
      tick();
    end
    tick();
    mem_store_type = NO_STORE;
    addr           = STATUS;
  endtask

  function automatic logic [63:0] rnd_data();
    logic [63:0] d;
    int unsigned r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 7);
      d[8*i +: 8] = (r == 0) ? 8'h00 : (r == 1) ? 8'h0A : 8'($urandom);
    end
    return d;
  endfunction

  function automatic logic [63:0] other_addr();
    case ($urandom_range(0, 3))
      0:       return BASE - 64'd8;
      1:       return STATUS;
      2:       return BASE + 64'd16;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin : driver
    int s;
    int unsigned kind;
    reset          = 1'b1;
    addr           = STATUS;
    mem_store_type = NO_STORE;
    w_data         = '0;
    out_ready      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(STATUS, 2);

    // Single byte straight through.
    rdy_mode = 1;
    do_store(BASE, STORE_BYTE, 64'h41, s);
    idle(STATUS, 4);

    // DWORD with a NUL in the top byte, at an unaligned window offset.
    do_store(BASE + 64'd3, STORE_DWORD, 64'h000A_216F_6C6C_6548, s);
    idle(STATUS, 12);

    // Fill the FIFO with the host stalled.
    rdy_mode = 0;
    idle(STATUS, 1);
    for (int i = 0; i < 16; i++) do_store(BASE, STORE_BYTE, 64'(8'h30 + 8'(i)), s);
    @(negedge clock);
    check("full_count", 64'(r_data[15:8]), 64'd16);
    check("full_flag", 64'(r_data[0]), 64'd1);
    addr = BASE;
    mem_store_type = STORE_BYTE;
    w_data = 64'h5A;
    @(negedge clock);
    check("full_stall", 64'(stall), 64'd1);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    do_store(BASE, STORE_BYTE, 64'h5A, s);
    check("after_pop_stalls", 64'(s), 64'd0);
    @(negedge clock);
    check("refill_count", 64'(r_data[15:8]), 64'd16);
    rdy_mode = 1;
    do_store(BASE, STORE_BYTE, 64'h0A, s);
    idle(STATUS, 24);

    // WORD followed at once by a BYTE.
    do_store(BASE, STORE_WORD, 64'hDEAD_BEEF_4443_4241, s);
    do_store(BASE + 64'd1, STORE_BYTE, 64'h45, s);
    check("word_then_byte_stalls", 64'(s), 64'd4);
    idle(STATUS, 6);

    // Reset in the third SPLIT cycle of a DWORD.
    rdy_mode = 0;
    do_store(BASE, STORE_DWORD, 64'h1122_3344_5566_7788, s);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    addr = STATUS;
    @(negedge clock);
    check("post_reset_status", r_data, 64'h2);
    check("post_reset_valid", 64'(out_valid), 64'd0);
    check("post_reset_stall", 64'(stall), 64'd0);
    rdy_mode = 1;
    idle(STATUS, 2);

    // Line without newline, then the newline.
    do_store(BASE, STORE_BYTE, 64'h61, s);
    do_store(BASE, STORE_BYTE, 64'h62, s);
    idle(STATUS, 3);
    do_store(BASE, STORE_BYTE, 64'h0A, s);
    idle(STATUS, 6);

    // Randomized traffic with random host backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)
        do_store(BASE + 64'($urandom_range(0, 7)),
                 mem_store_type_t'(2'($urandom_range(1, 3))), rnd_data(), s);
      else if (kind < 8)
        do_store(other_addr(), mem_store_type_t'(2'($urandom_range(0, 3))), rnd_data(), s);
      else
        idle(STATUS, int'($urandom_range(1, 3)));
    end

    // Final newline lets any buffered line drain, then wait for the host.
    rdy_mode = 1;
    do_store(BASE, STORE_BYTE, 64'h0A, s);
    for (int k = 0; k < BUDGET && sb_q.size() != 0; k++) tick();
    idle(STATUS, 2);
    @(negedge clock);
    check("drain_remaining", 64'(sb_q.size()), 64'd0);
    check("drain_status", r_data, 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stdout_ctrl.md
Name: stdout_ctrl

Overview:
- Simulation-console controller between the core's store port and the host console.
- Decodes stores to the stdout MMIO window and serializes WORD/DWORD stores into bytes, one per cycle.
- Queues the bytes in a FIFO and drains them to the testbench/host over a valid/ready byte stream.
- Backpressures the core with `stall` when it cannot accept a store, and exposes a readable status word.

Parameters:
- DEPTH, 16, FIFO entries (bytes); power of two, ≥4.
- SKIP_NUL, 1, when 1, 0x00 bytes from WORD/DWORD stores are not enqueued.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- addr  in  64  core data address
- mem_store_type  in  mem_store_type_t  NO_STORE/STORE_BYTE/STORE_WORD/STORE_DWORD
- w_data  in  64  store data
- stall  out  1  core must hold addr/mem_store_type/w_data stable
- r_data  out  64  status word; valid when addr == STDOUT_STATUS_ADDR
- stdout_taken  out  1  registered one-cycle pulse after a store is accepted
- out_valid  out  1  byte available to host
- out_byte  out  8  FIFO head
- out_ready  in  1  host consumes byte

Behaviour:
- Hit condition: addr in [STDOUT_BASE_ADDR, STDOUT_BASE_ADDR+8) and mem_store_type != NO_STORE.
- Two-state FSM, IDLE and SPLIT.
- IDLE + hit + BYTE:
  - FIFO not full: accept; enqueue w_data[7:0] this edge (enqueued even if 0x00); stall=0.
  - FIFO full: stall=1, nothing accepted.
- IDLE + hit + WORD/DWORD:
  - Always accepted; stall=0.
  - Latch w_data into a 64-bit shift register; remaining = 4 (w_data[31:0]) or 8; go to SPLIT.
- SPLIT:
  - Each cycle FIFO not full: enqueue shift[7:0] unless (SKIP_NUL && byte == 0); shift right 8; remaining−1.
  - remaining reaches 0: go to IDLE.
  - FIFO full: hold.
- Byte order: little-endian, low byte first, independent of addr[2:0].
- stall is combinational: stall = hit && !(state == IDLE && (type != STORE_BYTE || !full)). Never asserted without a hit, so a non-stdout store in SPLIT proceeds.
- stdout_taken is registered: 1 in the cycle after any accept, else 0.
- FIFO:
  - Registered count 0..DEPTH, full = (count == DEPTH), empty = (count == 0).
  - Push decided on registered full; a pop in the same cycle does not free space for that cycle's push.
  - Simultaneous push+pop when not full or empty: count unchanged.
  - Pointers wrap modulo DEPTH.
- Drain: out_valid = !empty (gated, see Optional Feature); out_byte = head; pop when out_valid && out_ready.
- Status word r_data (combinational, 0 when not addressed): bit0 full, bit1 empty, bit2 busy (state == SPLIT), bits[15:8] count, rest 0.
- Reset values: state IDLE, count 0, pointers 0, shift 0, stdout_taken 0, out_valid 0, stall 0. Reset mid-SPLIT discards the pending bytes and FIFO contents.

Optional Feature:
- Macro: STDOUT_LINE_BUFFER_EN.
- Defined:
  - Per-FIFO newline counter: +1 on enqueue of 0x0A, −1 on pop of 0x0A.
  - out_valid = !empty && (nl_count != 0 || full).
- Undefined: out_valid = !empty; no newline counter.

Decomposition:
- Existing package `structures`: reuse mem_store_type_t and STORE_*.
- `configurations`: add STDOUT_STATUS_ADDR = STDOUT_BASE_ADDR + 8 and STDOUT_FIFO_DEPTH = 16.
- Sub-module: `stdout_fifo` (byte FIFO with push/pop, count, full/empty). The FSM, decode and status mux stay in stdout_ctrl.

Test Plan:
- BYTE 0x41 to base, out_ready=1 → stall 0; stdout_taken=1 next cycle; out_valid=1, out_byte=0x41 next cycle; count back to 0 after pop.
- DWORD w_data=64'h000A_216F_6C6C_6548, out_ready=1 → SPLIT for 8 cycles; host receives 48 65 6C 6C 6F 21 0A in order; the NUL is skipped; busy=1 during SPLIT.
- out_ready=0, 16 BYTE stores → status count=16, full=1; 17th BYTE store holds stall=1; one out_ready pulse → stall drops the following cycle and the store is accepted; count=16.
- WORD store followed immediately by BYTE store → BYTE stalled 4 cycles until IDLE, then accepted; output order is the WORD bytes then the BYTE.
- reset asserted in the 3rd SPLIT cycle of a DWORD → next cycle out_valid=0, count=0, state IDLE, stall=0.
- STDOUT_LINE_BUFFER_EN defined: BYTEs 0x61, 0x62 → out_valid stays 0; BYTE 0x0A → out_valid=1 and 61 62 0A drain, then out_valid=0.
